regfile_mp_sb: RTL

Parametrised multi-port integer register file with an integrated pending-write scoreboard, for the pipelined core. It provides NRD combinational read ports and NWR synchronous write ports, with write-to-read bypass. Each register has a busy bit that is set when a producer issues and cleared when that producer writes back. Decode uses these busy bits for stall and hazard detection.

---
 rtl/regfile_mp_sb_pkg.sv | 20 ++
 rtl/regfile_mp_sb_if.sv | 46 ++++
 rtl/regfile_mp_sb_busy_tracker.sv | 93 +++++++++
 rtl/regfile_mp_sb.sv | 111 +++++++++++
 4 files changed

// File: rtl/regfile_mp_sb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb_pkg
// Shared constants and types for the multi-port register file and its
// pending-write scoreboard.
//   STACK_TOP  : reset value of the stack pointer register
//   SP_IDX     : architectural index of the stack pointer
//   REG_ZERO   : hard-wired zero register index
//   reg_addr_t : register address type for the default 32-entry file
// ---------------------------------------------------------------------------
package regfile_mp_sb_pkg;

  localparam logic [31:0] STACK_TOP  = 32'h0001_FFF0;
  localparam int          SP_IDX     = 2;
  localparam int          REG_ZERO   = 0;
  localparam int          NREGS_DEF  = 32;
  localparam int          AWIDTH_DEF = $clog2(NREGS_DEF);

  typedef logic [AWIDTH_DEF-1:0] reg_addr_t;

endpackage : regfile_mp_sb_pkg

// File: rtl/regfile_mp_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb_if
// Bundles the read, write, allocate and scoreboard signals of the register
// file. The master modport is the pipeline (decode/writeback) side, the
// slave modport is the register file itself.
//   rd_addr_i / rd_data_o / rd_busy_o : NRD combinational read ports
//   wr_en_i / wr_addr_i / wr_data_i   : NWR write ports, higher index wins
//   alloc_en_i / alloc_addr_i         : mark a destination as pending
//   flush_i                           : clear all pending bits
//   busy_vec_o / pending_cnt_o        : registered scoreboard state
//   wr_conflict_o                     : registered same-target write pulse
// ---------------------------------------------------------------------------
interface regfile_mp_sb_if #(
  parameter int DWIDTH = 32,
  parameter int NREGS  = 32,
  parameter int AWIDTH = $clog2(NREGS),
  parameter int NRD    = 2,
  parameter int NWR    = 2
);

  logic [NRD*AWIDTH-1:0] rd_addr_i;
  logic [NRD*DWIDTH-1:0] rd_data_o;
  logic [NRD-1:0]        rd_busy_o;
  logic [NWR-1:0]        wr_en_i;
  logic [NWR*AWIDTH-1:0] wr_addr_i;
  logic [NWR*DWIDTH-1:0] wr_data_i;
  logic                  alloc_en_i;
  logic [AWIDTH-1:0]     alloc_addr_i;
  logic                  flush_i;
  logic [NREGS-1:0]      busy_vec_o;
  logic [AWIDTH:0]       pending_cnt_o;
  logic                  wr_conflict_o;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
           alloc_en_i, alloc_addr_i, flush_i,
    input  rd_data_o, rd_busy_o, busy_vec_o, pending_cnt_o, wr_conflict_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
           alloc_en_i, alloc_addr_i, flush_i,
    output rd_data_o, rd_busy_o, busy_vec_o, pending_cnt_o, wr_conflict_o
  );

endinterface : regfile_mp_sb_if

// File: rtl/regfile_mp_sb_busy_tracker.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb_busy_tracker
// Pending-write scoreboard: one busy bit per register, its population count
// and a one-cycle flag for two write ports hitting the same register.
//   clk, rst (async, active-low)
//   wr_en_i, wr_addr_i        : write-back ports (clear busy)
//   alloc_en_i, alloc_addr_i  : producer issue (set busy)
//   flush_i                   : clear every busy bit
//   busy_vec_o, pending_cnt_o : registered busy bits and their count
//   wr_conflict_o             : registered write-target collision pulse
// ---------------------------------------------------------------------------
module regfile_mp_sb_busy_tracker
  import regfile_mp_sb_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NWR    = 2,
  parameter int AWIDTH = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        wr_en_i,
  input  logic [NWR*AWIDTH-1:0] wr_addr_i,
  input  logic                  alloc_en_i,
  input  logic [AWIDTH-1:0]     alloc_addr_i,
  input  logic                  flush_i,
  output logic [NREGS-1:0]      busy_vec_o,
  output logic [AWIDTH:0]       pending_cnt_o,
  output logic                  wr_conflict_o
);

  localparam int CW = AWIDTH + 1;

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             conf_q, conf_d;
  logic [NREGS-1:0] wr_hit;

  always_comb begin
    wr_hit = '0;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en_i[w]) wr_hit[wr_addr_i[w*AWIDTH +: AWIDTH]] = 1'b1;
    end

    // Alloc beats flush and write-back: a newly issued producer must stay
    // visible even when an older one retires or the pipe is squashed.
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (r == REG_ZERO) begin
        busy_d[r] = 1'b0;
      end else if (alloc_en_i && (alloc_addr_i == AWIDTH'(r))) begin
        busy_d[r] = 1'b1;
      end else if (flush_i) begin
        busy_d[r] = 1'b0;
      end else if (wr_hit[r]) begin
        busy_d[r] = 1'b0;
      end
    end

    // Count is taken from the next vector so both register together.
    cnt_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d = cnt_d + CW'(busy_d[r]);
    end

    conf_d = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (wr_en_i[i] && wr_en_i[j] &&
            (wr_addr_i[i*AWIDTH +: AWIDTH] == wr_addr_i[j*AWIDTH +: AWIDTH]) &&
            (wr_addr_i[i*AWIDTH +: AWIDTH] != AWIDTH'(REG_ZERO))) begin
          conf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      conf_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      conf_q <= conf_d;
    end
  end

  assign busy_vec_o    = busy_q;
  assign pending_cnt_o = cnt_q;
  assign wr_conflict_o = conf_q;

endmodule : regfile_mp_sb_busy_tracker

// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb
// Multi-port integer register file with integrated pending-write scoreboard.
// NRD combinational read ports, NWR synchronous write ports (higher index
// wins), optional same-cycle write-to-read forwarding, register 0 hard-wired
// to zero and the stack pointer reset to SP_INIT.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : regfile_mp_sb_if slave modport (read/write/alloc/scoreboard)
// ---------------------------------------------------------------------------
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int                DWIDTH  = 32,
  parameter int                NREGS   = 32,
  parameter int                AWIDTH  = $clog2(NREGS),
  parameter int                NRD     = 2,
  parameter int                NWR     = 2,
  parameter logic [DWIDTH-1:0] SP_INIT = DWIDTH'(STACK_TOP),
  parameter bit                BYPASS  = 1'b1
) (
  input logic            clk,
  input logic            rst,
  regfile_mp_sb_if.slave bus
);

  logic [DWIDTH-1:0] regs_q [NREGS];
  logic [DWIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_vec;
  logic [AWIDTH:0]   pending_cnt;
  logic              wr_conflict;

  // Later ports overwrite earlier ones, giving the higher index priority.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NWR; w++) begin
      if (bus.wr_en_i[w] &&
          (bus.wr_addr_i[w*AWIDTH +: AWIDTH] != AWIDTH'(REG_ZERO))) begin
        regs_d[bus.wr_addr_i[w*AWIDTH +: AWIDTH]] = bus.wr_data_i[w*DWIDTH +: DWIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= (r == SP_IDX) ? SP_INIT : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_mp_sb_busy_tracker #(
    .NREGS  (NREGS),
    .NWR    (NWR),
    .AWIDTH (AWIDTH)
  ) u_busy (
    .clk           (clk),
    .rst           (rst),
    .wr_en_i       (bus.wr_en_i),
    .wr_addr_i     (bus.wr_addr_i),
    .alloc_en_i    (bus.alloc_en_i),
    .alloc_addr_i  (bus.alloc_addr_i),
    .flush_i       (bus.flush_i),
    .busy_vec_o    (busy_vec),
    .pending_cnt_o (pending_cnt),
    .wr_conflict_o (wr_conflict)
  );

  assign bus.busy_vec_o    = busy_vec;
  assign bus.pending_cnt_o = pending_cnt;
  assign bus.wr_conflict_o = wr_conflict;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AWIDTH-1:0] ra;
    logic              hit;
    logic [DWIDTH-1:0] fwd;
    logic [DWIDTH-1:0] data;
    logic              busy;

    assign ra = bus.rd_addr_i[gi*AWIDTH +: AWIDTH];

    always_comb begin
      hit = 1'b0;
      fwd = '0;
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en_i[w] && (bus.wr_addr_i[w*AWIDTH +: AWIDTH] == ra)) begin
          hit = 1'b1;
          fwd = bus.wr_data_i[w*DWIDTH +: DWIDTH];
        end
      end

      if (ra == AWIDTH'(REG_ZERO)) begin
        data = '0;
        busy = 1'b0;
      end else if (BYPASS && hit) begin
        // Forwarded data satisfies the consumer, so it is no longer busy.
        data = fwd;
        busy = 1'b0;
      end else begin
        data = regs_q[ra];
        busy = busy_vec[ra];
      end
    end

    assign bus.rd_data_o[gi*DWIDTH +: DWIDTH] = data;
    assign bus.rd_busy_o[gi]                  = busy;
  end

endmodule : regfile_mp_sb
